// File: rtl/pc_gen_if.sv
// Fetch-address generator port bundle: stall/redirect inputs and the registered fetch outputs.
// misalign_o exists only when PC_MISALIGN_EXC_EN is defined.
interface pc_gen_if #(
    parameter int ADDR_W  = 32,
    parameter int ISSUE_W = 2
);
    logic [5:0]         stall;
    logic               branch_flag_i;
    logic [ADDR_W-1:0]  target_addr_i;
    logic               flush_i;
    logic [ADDR_W-1:0]  new_pc_i;
    logic [ADDR_W-1:0]  pc;
    logic               ce;
    logic [ISSUE_W-1:0] slot_mask;
    logic               redirect_pending_o;
`ifdef PC_MISALIGN_EXC_EN
    logic               misalign_o;
`endif

    modport master (
        output stall, branch_flag_i, target_addr_i, flush_i, new_pc_i,
`ifdef PC_MISALIGN_EXC_EN
        input  misalign_o,
`endif
        input  pc, ce, slot_mask, redirect_pending_o
    );

    modport slave (
        input  stall, branch_flag_i, target_addr_i, flush_i, new_pc_i,
`ifdef PC_MISALIGN_EXC_EN
        output misalign_o,
`endif
        output pc, ce, slot_mask, redirect_pending_o
    );
endinterface

// File: rtl/pc_gen.sv
// Multi-issue fetch-group address generator with flush/branch priority and stall-safe redirect hold.
// Optional PC_MISALIGN_EXC_EN: keep misaligned targets and flag them instead of forcing alignment.
module pc_gen #(
    parameter int                ADDR_W       = 32,
    parameter int                ISSUE_W      = 2,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
    input  logic   clk,
    input  logic   rst,
    pc_gen_if.slave fe
);
    localparam int GB = 4 * ISSUE_W;

    typedef enum logic [1:0] {OFF, RUN, HOLD} state_t;

    state_t             state, state_nxt;
    logic [ADDR_W-1:0]  pc_q, pc_nxt, seq_pc;
    logic [ISSUE_W-1:0] mask_q;
    logic               ce_q, pend_q, load;
    logic [ADDR_W-1:0]  pend_tgt, pend_tgt_nxt;
    logic               pend_flush, pend_flush_nxt;
    logic               stall0, redir_vld, take_new;
    logic [ADDR_W-1:0]  redir_tgt;
    logic               unused_stall;

    function automatic logic [ADDR_W-1:0] align_tgt(input logic [ADDR_W-1:0] a);
`ifdef PC_MISALIGN_EXC_EN
        return a;
`else
        return {a[ADDR_W-1:2], 2'b00};
`endif
    endfunction

    // Slots before the entry offset within the group are not issued.
    function automatic logic [ISSUE_W-1:0] mask_of(input logic [ADDR_W-1:0] a);
        logic [ISSUE_W-1:0] m;
        int off;
        off = int'((a >> 2) & ADDR_W'(ISSUE_W - 1));
        for (int i = 0; i < ISSUE_W; i++) m[i] = (i >= off);
`ifdef PC_MISALIGN_EXC_EN
        if (a[1:0] != 2'b00) m = '0;
`endif
        return m;
    endfunction

    assign unused_stall = ^fe.stall[5:1];
    assign stall0       = fe.stall[0];
    assign redir_vld    = fe.flush_i | fe.branch_flag_i;
    assign redir_tgt    = align_tgt(fe.flush_i ? fe.new_pc_i : fe.target_addr_i);
    // A branch may not displace a pending flush.
    assign take_new     = fe.flush_i | (fe.branch_flag_i & ~pend_flush);
    assign seq_pc       = (pc_q & ~ADDR_W'(GB - 1)) + ADDR_W'(GB);

    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc_q;
        load           = 1'b0;
        pend_tgt_nxt   = pend_tgt;
        pend_flush_nxt = pend_flush;
        case (state)
            OFF: state_nxt = RUN;
            RUN: begin
                if (!stall0) begin
                    load   = 1'b1;
                    pc_nxt = redir_vld ? redir_tgt : seq_pc;
                end else if (redir_vld) begin
                    pend_tgt_nxt   = redir_tgt;
                    pend_flush_nxt = fe.flush_i;
                    state_nxt      = HOLD;
                end
            end
            HOLD: begin
                if (stall0) begin
                    if (take_new) begin
                        pend_tgt_nxt   = redir_tgt;
                        pend_flush_nxt = fe.flush_i;
                    end
                end else begin
                    load           = 1'b1;
                    pc_nxt         = take_new ? redir_tgt : pend_tgt;
                    pend_flush_nxt = 1'b0;
                    state_nxt      = RUN;
                end
            end
            default: state_nxt = OFF;
        endcase
    end

`ifdef PC_MISALIGN_EXC_EN
    logic misalign_q;
    always_ff @(posedge clk) begin
        if (rst)       misalign_q <= 1'b0;
        else if (load) misalign_q <= (pc_nxt[1:0] != 2'b00);
    end
    assign fe.misalign_o = misalign_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= OFF;
            pc_q       <= RESET_VECTOR;
            mask_q     <= '1;
            ce_q       <= 1'b0;
            pend_q     <= 1'b0;
            pend_tgt   <= '0;
            pend_flush <= 1'b0;
        end else begin
            state      <= state_nxt;
            ce_q       <= (state_nxt != OFF);
            pend_q     <= (state_nxt == HOLD);
            pend_tgt   <= pend_tgt_nxt;
            pend_flush <= pend_flush_nxt;
            if (load) begin
                pc_q   <= pc_nxt;
                mask_q <= mask_of(pc_nxt);
            end
        end
    end

    assign fe.pc                 = pc_q;
    assign fe.ce                 = ce_q;
    assign fe.slot_mask          = mask_q;
    assign fe.redirect_pending_o = pend_q;
endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen (ISSUE_W=2, RESET_VECTOR=0x100); expectations hand-computed.
module tb_pc_gen;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;

    pc_gen_if #(.ADDR_W(32), .ISSUE_W(2)) fe ();
    pc_gen #(.ADDR_W(32), .ISSUE_W(2), .RESET_VECTOR(32'h100)) dut (.clk(clk), .rst(rst), .fe(fe));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance one edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic st, input logic br, input logic [31:0] tgt,
                         input logic fl, input logic [31:0] npc);
        fe.stall         = {5'b0, st};
        fe.branch_flag_i = br;
        fe.target_addr_i = tgt;
        fe.flush_i       = fl;
        fe.new_pc_i      = npc;
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0);
        step(); step();
        chk("rst_ce",   32'(fe.ce), 0);
        chk("rst_pc",   fe.pc, 32'h100);
        chk("rst_mask", 32'(fe.slot_mask), 32'h3);
        chk("rst_pend", 32'(fe.redirect_pending_o), 0);

        rst = 1'b0;
        step();
        chk("on_ce", 32'(fe.ce), 1);
        chk("on_pc", fe.pc, 32'h100);
        step(); chk("seq1_pc", fe.pc, 32'h108);
        step(); chk("seq2_pc", fe.pc, 32'h110);
        chk("seq2_mask", 32'(fe.slot_mask), 32'h3);

        drive(0, 1, 32'h204, 0, 0);
        step(); chk("br_pc", fe.pc, 32'h204); chk("br_mask", 32'(fe.slot_mask), 32'h2);
        drive(0, 0, 0, 0, 0);
        step(); chk("br_next_pc", fe.pc, 32'h208); chk("br_next_mask", 32'(fe.slot_mask), 32'h3);

        // Branch arriving in the first of three stall cycles.
        drive(1, 1, 32'h400, 0, 0);
        step(); chk("st1_pc", fe.pc, 32'h208); chk("st1_pend", 32'(fe.redirect_pending_o), 1);
        drive(1, 0, 0, 0, 0);
        step(); chk("st2_pc", fe.pc, 32'h208); chk("st2_pend", 32'(fe.redirect_pending_o), 1);
        step(); chk("st3_pc", fe.pc, 32'h208); chk("st3_pend", 32'(fe.redirect_pending_o), 1);
        drive(0, 0, 0, 0, 0);
        step(); chk("rel_pc", fe.pc, 32'h400); chk("rel_pend", 32'(fe.redirect_pending_o), 0);

        // Pending flush must not be displaced by a later branch.
        drive(1, 0, 0, 1, 32'h80);
        step(); chk("fh_pend", 32'(fe.redirect_pending_o), 1);
        drive(1, 1, 32'h300, 0, 0);
        step(); chk("fh_hold_pc", fe.pc, 32'h400);
        drive(0, 0, 0, 0, 0);
        step(); chk("fh_rel_pc", fe.pc, 32'h80);

        // Pending branch is replaced by a newer branch.
        drive(1, 1, 32'h300, 0, 0);
        step();
        drive(1, 1, 32'h310, 0, 0);
        step();
        drive(0, 0, 0, 0, 0);
        step(); chk("bb_rel_pc", fe.pc, 32'h310); chk("bb_mask", 32'(fe.slot_mask), 32'h3);

        drive(0, 1, 32'h500, 1, 32'h20);
        step(); chk("prio_pc", fe.pc, 32'h20);

        drive(0, 1, 32'h102, 0, 0);
        step();
`ifdef PC_MISALIGN_EXC_EN
        chk("mis_pc", fe.pc, 32'h102);
        chk("mis_flag", 32'(fe.misalign_o), 1);
        chk("mis_mask", 32'(fe.slot_mask), 0);
`else
        chk("mis_pc", fe.pc, 32'h100);
        chk("mis_mask", 32'(fe.slot_mask), 32'h3);
`endif
        drive(0, 0, 0, 0, 0);
        step(); chk("mis_seq_pc", fe.pc, 32'h108);
`ifdef PC_MISALIGN_EXC_EN
        chk("mis_seq_flag", 32'(fe.misalign_o), 0);
`endif
        chk("mis_seq_mask", 32'(fe.slot_mask), 32'h3);

        drive(0, 1, 32'hFFFF_FFF8, 0, 0);
        step(); chk("wrap_top", fe.pc, 32'hFFFF_FFF8);
        drive(0, 0, 0, 0, 0);
        step(); chk("wrap_zero", fe.pc, 32'h0);

        // Reset while a redirect is pending discards it.
        drive(1, 1, 32'h600, 0, 0);
        step(); chk("rp_pend", 32'(fe.redirect_pending_o), 1);
        rst = 1'b1;
        drive(0, 0, 0, 0, 0);
        step();
        chk("rp_ce", 32'(fe.ce), 0); chk("rp_pc", fe.pc, 32'h100);
        chk("rp_pend_clr", 32'(fe.redirect_pending_o), 0);
        rst = 1'b0;
        step(); chk("rp_on_pc", fe.pc, 32'h100); chk("rp_on_ce", 32'(fe.ce), 1);
        step(); chk("rp_seq_pc", fe.pc, 32'h108);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised fetch-address generator for the multi-issue front end. It produces one aligned fetch-group address per cycle plus a per-slot valid mask. It applies exception flushes and branch redirects with fixed priority, and holds a redirect that arrives during a fetch stall so it is not lost. It sits in the IF stage, driven by the stall controller, the branch unit in EX and the exception logic in MEM.

## Interface
- ADDR_W, 32, PC and target width in bits
- ISSUE_W, 2, instructions per fetch group; power of two, 1..8; group size GB = 4*ISSUE_W bytes
- RESET_VECTOR, 32'h0000_0000, PC loaded on reset; must be GB-aligned
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  synchronous reset, active-high
- stall  in  6  pipeline stall vector; only stall[0] (fetch stall, 1 = hold) is used
- branch_flag_i  in  1  branch taken in EX
- target_addr_i  in  ADDR_W  branch target
- flush_i  in  1  exception or eret flush
- new_pc_i  in  ADDR_W  flush target
- pc  out  ADDR_W  current fetch address
- ce  out  1  instruction memory chip enable
- slot_mask  out  ISSUE_W  bit i = 1 if slot i of the group at pc is to be issued
- redirect_pending_o  out  1  a redirect is latched and waiting for the stall to clear
- misalign_o  out  1  pc[1:0] != 0; present only with PC_MISALIGN_EXC_EN

## Operation
- States: OFF (ce=0), RUN (ce=1, no pending redirect), HOLD (ce=1, pending redirect held).
- Edge with rst=1: state OFF, ce=0, pc=RESET_VECTOR, slot_mask=all ones, pending cleared, misalign_o=0.
- OFF, rst=0: go to RUN and set ce=1. pc is unchanged.
- Candidate redirect each cycle:
  - flush_i=1 gives new_pc_i.
  - Otherwise branch_flag_i=1 gives target_addr_i.
  - A flush always overrides a branch in the same cycle.
- RUN, stall[0]=0:
  - If a redirect is present, pc = its target.
  - Otherwise pc = (pc & ~(GB-1)) + GB.
- RUN, stall[0]=1:
  - pc holds.
  - A redirect is latched as pending (target and a flush/branch kind bit), and the state goes to HOLD.
- HOLD, stall[0]=1:
  - pc holds.
  - A new flush overwrites any pending entry.
  - A new branch overwrites a pending branch, but is dropped if the pending entry is a flush.
- HOLD, stall[0]=0:
  - If a new redirect is present, it wins under the same overwrite rule as above.
  - Otherwise pc = the pending target.
  - Pending is cleared and the state goes to RUN.
- slot_mask is registered alongside pc. With off = pc[log2(GB)-1:2], slot_mask = ({ISSUE_W{1'b1}} << off) truncated to ISSUE_W. A sequential advance always gives all ones.
- Address arithmetic is modulo 2^ADDR_W; wrap past all-ones to 0 is legal and silent.
- redirect_pending_o = (state == HOLD).

## Timing
- Redirect latency: a redirect sampled at edge N with stall[0]=0 appears on pc after edge N, i.e. during cycle N+1.
- A redirect held across stall cycles appears after the first edge with stall[0]=0.
- ce rises one edge after rst falls. The first fetch is RESET_VECTOR, presented for the cycle in which ce=1.
- Reset mid-operation discards any pending redirect within the same edge.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- PC_MISALIGN_EXC_EN defined:
  - A redirect target with [1:0] != 0 is loaded unmodified.
  - misalign_o=1 while pc holds it, and slot_mask=0 so nothing issues.
  - The next sequential advance clears misalign_o.
- PC_MISALIGN_EXC_EN undefined:
  - Target bits [1:0] are forced to 0 on load.
  - The misalign_o port does not exist.

## Test plan
- Reset then release, ISSUE_W=2, RESET_VECTOR=0x100 -> ce=0/pc=0x100 during reset; then ce=1 with pc sequence 0x100, 0x108, 0x110; slot_mask=2'b11 throughout.
- Branch to 0x204 with no stall (ISSUE_W=2) -> next pc=0x204, slot_mask=2'b10; following pc=0x208, slot_mask=2'b11.
- stall[0]=1 for 3 cycles, branch to 0x400 in the first stall cycle -> pc frozen; redirect_pending_o=1 for 3 cycles; pc=0x400 after stall release.
- In HOLD with a pending flush to 0x80, assert branch to 0x300, then release the stall -> pc=0x80; the branch is dropped.
- flush_i=1 (new_pc_i=0x20) and branch_flag_i=1 (0x500) in the same cycle -> pc=0x20.
- With the macro, branch to 0x102 -> pc=0x102, misalign_o=1, slot_mask=0. Without the macro, the same branch gives pc=0x100, slot_mask=2'b11.
